// File: rtl/alu_multicycle_pkg.sv
// Shared definitions for the multicycle ALU: op-codes, FSM states and the
// registered flag bundle.
package alu_multicycle_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_ADD = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB = 3'd1;
    localparam logic [OP_W-1:0] OP_XOR = 3'd2;
    localparam logic [OP_W-1:0] OP_SLT = 3'd3;
    localparam logic [OP_W-1:0] OP_MUL = 3'd4;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    // Status flags reported alongside every result.
    typedef struct packed {
        logic carry_out;
        logic overflow;
        logic zero;
        logic illegal_op;
    } alu_flags_t;

endpackage

// File: rtl/alu_comb.sv
// Combinational ADD/SUB/XOR/SLT datapath for the single-cycle ops.
// Ports: op (3b op-code), a/b (WIDTH operands), result_c (WIDTH result),
//        carry_c, overflow_c (ADD/SUB only), illegal_c (op-code 5-7).
// MUL and illegal op-codes produce a zero result here.
module alu_comb
    import alu_multicycle_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result_c,
    output logic             carry_c,
    output logic             overflow_c,
    output logic             illegal_c
);

    localparam int unsigned SW = WIDTH + 1;

    logic             sub;
    logic [WIDTH-1:0] bx;
    logic [SW-1:0]    sum;
    logic             msb_cin;
    logic             add_ovf;

    // SLT reuses the subtractor.
    assign sub     = (op == OP_SUB) || (op == OP_SLT);
    assign bx      = b ^ {WIDTH{sub}};
    assign sum     = {1'b0, a} + {1'b0, bx} + SW'(sub);
    // Carry into the MSB recovered from the MSB sum bit.
    assign msb_cin = a[WIDTH-1] ^ bx[WIDTH-1] ^ sum[WIDTH-1];
    assign add_ovf = msb_cin ^ sum[WIDTH];

    // Result/flag select.
    always_comb begin
        result_c   = '0;
        carry_c    = 1'b0;
        overflow_c = 1'b0;
        illegal_c  = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                result_c   = sum[WIDTH-1:0];
                carry_c    = sum[WIDTH];
                overflow_c = add_ovf;
            end
            OP_XOR: result_c = a ^ b;
            OP_SLT: result_c = WIDTH'(sum[WIDTH-1] ^ add_ovf);
            OP_MUL: result_c = '0;
            default: illegal_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_multicycle.sv
// Clocked ALU: single-cycle ADD/SUB/XOR/SLT plus a WIDTH-cycle shift-add
// unsigned multiply, behind a start/busy/done handshake.
// Ports: clk, reset (sync, active-high), start, op (3b), a, b (WIDTH);
//        result, result_hi (WIDTH), carry_out, overflow, zero, illegal_op,
//        busy, done -- all registered, all 0 after reset.
module alu_multicycle
    import alu_multicycle_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             illegal_op,
    output logic             busy,
    output logic             done
);

    localparam int unsigned PW = 2 * WIDTH;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] result_nxt, result_hi_nxt;
    alu_flags_t       flags_q, flags_nxt;
    logic             busy_nxt, done_nxt;
    logic [PW-1:0]    mcand, mcand_nxt;
    logic [PW-1:0]    acc, acc_nxt, acc_sum;
    logic [WIDTH-1:0] mplier, mplier_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic [WIDTH-1:0] c_result;
    logic             c_carry, c_overflow, c_illegal;

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .op         (op),
        .a          (a),
        .b          (b),
        .result_c   (c_result),
        .carry_c    (c_carry),
        .overflow_c (c_overflow),
        .illegal_c  (c_illegal)
    );

    assign carry_out  = flags_q.carry_out;
    assign overflow   = flags_q.overflow;
    assign zero       = flags_q.zero;
    assign illegal_op = flags_q.illegal_op;

    // Partial-product add for the current multiplier bit; mcand is pre-shifted.
    assign acc_sum = acc + (mplier[0] ? mcand : PW'(0));

    // Next-state and next-output logic.
    always_comb begin
        state_nxt     = state;
        result_nxt    = result;
        result_hi_nxt = result_hi;
        flags_nxt     = flags_q;
        busy_nxt      = busy;
        done_nxt      = 1'b0;
        mcand_nxt     = mcand;
        acc_nxt       = acc;
        mplier_nxt    = mplier;
        cnt_nxt       = cnt;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (op == OP_MUL) begin
                        mcand_nxt  = {{WIDTH{1'b0}}, a};
                        mplier_nxt = b;
                        acc_nxt    = '0;
                        cnt_nxt    = '0;
                        busy_nxt   = 1'b1;
                        state_nxt  = S_MUL;
                    end else begin
                        result_nxt           = c_result;
                        result_hi_nxt        = '0;
                        flags_nxt.carry_out  = c_carry;
                        flags_nxt.overflow   = c_overflow;
                        flags_nxt.zero       = (c_result == '0);
                        flags_nxt.illegal_op = c_illegal;
                        done_nxt             = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_nxt    = acc_sum;
                mcand_nxt  = mcand << 1;
                mplier_nxt = mplier >> 1;
                cnt_nxt    = cnt + CNT_W'(1);
                // Last iteration folds in the final partial product directly.
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    {result_hi_nxt, result_nxt} = acc_sum;
                    flags_nxt.carry_out  = 1'b0;
                    flags_nxt.overflow   = 1'b0;
                    flags_nxt.zero       = (acc_sum == '0);
                    flags_nxt.illegal_op = 1'b0;
                    done_nxt             = 1'b1;
                    busy_nxt             = 1'b0;
                    state_nxt            = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            result    <= '0;
            result_hi <= '0;
            flags_q   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mcand     <= '0;
            acc       <= '0;
            mplier    <= '0;
            cnt       <= '0;
        end else begin
            state     <= state_nxt;
            result    <= result_nxt;
            result_hi <= result_hi_nxt;
            flags_q   <= flags_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            mcand     <= mcand_nxt;
            acc       <= acc_nxt;
            mplier    <= mplier_nxt;
            cnt       <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle at WIDTH=8.
module tb_alu_multicycle;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] result, result_hi;
    logic         carry_out, overflow, zero, illegal_op, busy, done;

    alu_multicycle #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .result     (result),
        .result_hi  (result_hi),
        .carry_out  (carry_out),
        .overflow   (overflow),
        .zero       (zero),
        .illegal_op (illegal_op),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         c;
        logic         v;
        logic         z;
        logic         ill;
        int           due;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model built from plain integer arithmetic.
    function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        int   sx, sy, t;
        logic [2*W-1:0] p;
        sx = int'($signed(x));
        sy = int'($signed(y));
        e.res = '0; e.hi = '0; e.c = 1'b0; e.v = 1'b0; e.z = 1'b0; e.ill = 1'b0; e.due = 0;
        case (o)
            3'd0: begin
                t = int'(x) + int'(y);
                e.res = W'(t);
                e.c = (t > 255);
                e.v = ((sx + sy) > 127) || ((sx + sy) < -128);
            end
            3'd1: begin
                t = int'(x) - int'(y);
                e.res = W'(t);
                e.c = (x >= y);
                e.v = ((sx - sy) > 127) || ((sx - sy) < -128);
            end
            3'd2: e.res = x ^ y;
            3'd3: e.res = (sx < sy) ? W'(1) : W'(0);
            3'd4: begin
                p = (2*W)'(int'(x) * int'(y));
                e.hi = p[2*W-1:W];
                e.res = p[W-1:0];
            end
            default: e.ill = 1'b1;
        endcase
        e.z = ({e.hi, e.res} == '0);
        return e;
    endfunction

    // Drive one accepted request at the current negedge; consumes one cycle.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        start = 1'b1; op = o; a = x; b = y;
        e = model(o, x, y);
        e.due = cyc + 1 + ((o == 3'd4) ? W : 0);
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic drain();
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    // Output monitor: every done pops one expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result",     32'(result),     32'(e.res));
                chk("result_hi",  32'(result_hi),  32'(e.hi));
                chk("carry_out",  32'(carry_out),  32'(e.c));
                chk("overflow",   32'(overflow),   32'(e.v));
                chk("zero",       32'(zero),       32'(e.z));
                chk("illegal_op", 32'(illegal_op), 32'(e.ill));
                chk("done_cycle", 32'(cyc),        32'(e.due));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        repeat (3) @(negedge clk);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_hi",     32'(result_hi), 32'd0);
        chk("rst_flags",  32'({carry_out, overflow, zero, illegal_op}), 32'd0);
        chk("rst_busy",   32'(busy), 32'd0);
        chk("rst_done",   32'(done), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single-cycle ops, back to back.
        issue(3'd0, 8'hFF, 8'h01);
        issue(3'd1, 8'h80, 8'h01);
        issue(3'd1, 8'h01, 8'h02);
        issue(3'd3, 8'hFF, 8'h01);
        issue(3'd3, 8'h01, 8'hFF);
        issue(3'd3, 8'h80, 8'h7F);
        issue(3'd2, 8'hA5, 8'h5A);
        drain();

        // Illegal op then four consecutive ADDs.
        issue(3'd5, 8'h12, 8'h34);
        issue(3'd0, 8'h01, 8'h02);
        issue(3'd0, 8'h7F, 8'h01);
        issue(3'd0, 8'h80, 8'h80);
        issue(3'd0, 8'h10, 8'h20);
        drain();

        // MUL timing; a start during busy must be ignored.
        issue(3'd4, 8'hFF, 8'hFF);
        start = 1'b0;
        nb = 0;
        for (int k = 0; k < 20; k++) begin
            if (!busy) break;
            nb++;
            if (k == 2) begin
                start = 1'b1; op = 3'd0; a = 8'h01; b = 8'h01;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        chk("mul_busy_cycles", 32'(nb), 32'd8);
        // Start in the done cycle is accepted.
        issue(3'd0, 8'h05, 8'h06);
        drain();

        issue(3'd4, 8'h00, 8'h5A);
        drain();
        issue(3'd4, 8'h80, 8'h02);
        drain();

        // Reset mid-MUL abandons it.
        issue(3'd4, 8'h12, 8'h34);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("midrst_busy",   32'(busy), 32'd0);
        chk("midrst_done",   32'(done), 32'd0);
        chk("midrst_result", 32'({result_hi, result}), 32'd0);
        chk("midrst_flags",  32'({carry_out, overflow, zero, illegal_op}), 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("midrst_no_done", 32'(done), 32'd0);
        end
        issue(3'd0, 8'h03, 8'h04);
        drain();

        // Random mix.
        for (int i = 0; i < 30; i++) begin
            logic [2:0]   o;
            logic [W-1:0] x, y;
            o = 3'($urandom_range(0, 7));
            x = W'($urandom);
            y = W'($urandom);
            issue(o, x, y);
            if (o == 3'd4) drain();
        end
        drain();
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
